// File: rtl/crc5_pkg.sv
// Shared CRC5 definitions for the token framer: polynomial, seed, FSM encoding
// and the single-bit Galois LFSR step.
package crc5_pkg;

   localparam logic [4:0] CRC5_POLY = 5'b00101;
   localparam logic [4:0] CRC5_INIT = 5'b11111;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      CRC
   } state_e;

   // x^5 + x^2 + 1, bits enter at the MSB end
   function automatic logic [4:0] crc5_step(input logic [4:0] lfsr, input logic bit_in);
      logic fb;
      fb = lfsr[4] ^ bit_in;
      return {lfsr[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'b00000);
   endfunction

endpackage

// File: rtl/crc5_lfsr.sv
// Serial Galois CRC5 register. Load wins over step; the owner decides when either happens.
module crc5_lfsr
   import crc5_pkg::*;
#(
   parameter logic [4:0] RESET_VAL = CRC5_INIT
) (
   input  logic       clk,
   input  logic       reset_l,
   input  logic       load,
   input  logic [4:0] init,
   input  logic       step,
   input  logic       bit_in,
   output logic [4:0] lfsr
);

   logic [4:0] lfsr_q;
   logic [4:0] lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (load) begin
         lfsr_d = init;
      end else if (step) begin
         lfsr_d = crc5_step(lfsr_q, bit_in);
      end
   end

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         lfsr_q <= RESET_VAL;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign lfsr = lfsr_q;

endmodule

// File: rtl/crc5_frame_ctrl.sv
// Token framer: serialises a payload LSB first, then the CRC5 field MSB first.
// Every output except in_ready is decoded from registered state.
module crc5_frame_ctrl
   import crc5_pkg::*;
#(
   parameter int unsigned PAYLOAD_W  = 11,
   parameter logic [4:0]  CRC_INIT   = CRC5_INIT,
   parameter bit          INVERT_OUT = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset_l,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [PAYLOAD_W-1:0] in_data,
   input  logic                 abort,
   output logic                 ser_out,
   output logic                 ser_valid,
   input  logic                 ser_ready,
   output logic                 sof,
   output logic                 eof,
   output logic [4:0]           crc5out,
   output logic                 crc_done,
   output logic                 busy
);

   localparam logic [3:0] LAST_DATA = 4'(PAYLOAD_W - 1);
   localparam logic [3:0] LAST_CRC  = 4'd4;

   state_e                 state_q;
   logic [3:0]             cnt_q;
   logic [PAYLOAD_W-1:0]   shift_q;
   logic [4:0]             crc_q;
   logic                   done_q;
   logic                   armed_q;

   logic [4:0]             lfsr_q;
   logic [4:0]             lfsr_nxt;
   logic [4:0]             field;
   logic [2:0]             crc_idx;
   logic                   cur_bit;
   logic                   accept;
   logic                   data_beat;

   assign crc_idx = 3'(LAST_CRC - cnt_q);

   always_comb begin
      cur_bit = 1'b0;
      unique case (state_q)
         DATA:    cur_bit = shift_q[0];
         CRC:     cur_bit = crc_q[crc_idx];
         default: cur_bit = 1'b0;
      endcase
   end

   assign accept    = in_valid & in_ready;
   assign data_beat = (state_q == DATA) & ser_ready & ~abort;
   assign lfsr_nxt  = crc5_step(lfsr_q, cur_bit);
   assign field     = INVERT_OUT ? ~lfsr_nxt : lfsr_nxt;

   crc5_lfsr #(
      .RESET_VAL (CRC_INIT)
   ) u_lfsr (
      .clk     (clk),
      .reset_l (reset_l),
      .load    (accept),
      .init    (CRC_INIT),
      .step    (data_beat),
      .bit_in  (cur_bit),
      .lfsr    (lfsr_q)
   );

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         crc_q   <= '0;
         done_q  <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         armed_q <= 1'b1;
         done_q  <= 1'b0;
         if (abort) begin
            state_q <= IDLE;
            cnt_q   <= '0;
         end else begin
            unique case (state_q)
               IDLE: begin
                  if (in_valid && armed_q) begin
                     shift_q <= in_data;
                     cnt_q   <= '0;
                     state_q <= DATA;
                  end
               end
               DATA: begin
                  if (ser_ready) begin
                     // Shifting keeps the current bit at index 0 and holds it across stalls
                     shift_q <= shift_q >> 1;
                     if (cnt_q == LAST_DATA) begin
                        crc_q   <= field;
                        cnt_q   <= '0;
                        state_q <= CRC;
                     end else begin
                        cnt_q <= cnt_q + 4'd1;
                     end
                  end
               end
               CRC: begin
                  if (ser_ready) begin
                     if (cnt_q == LAST_CRC) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                     end else begin
                        cnt_q <= cnt_q + 4'd1;
                     end
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign in_ready  = armed_q & (state_q == IDLE) & ~abort;
   assign ser_valid = (state_q != IDLE);
   assign ser_out   = cur_bit;
   assign sof       = (state_q == DATA) & (cnt_q == 4'd0);
   assign eof       = (state_q == CRC) & (cnt_q == LAST_CRC);
   assign crc5out   = crc_q;
   assign crc_done  = done_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_crc5_frame_ctrl.sv
// Directed and table-driven bench for crc5_frame_ctrl with an independent CRC5 model
// and receiver-side residual check.
module tb_crc5_frame_ctrl;

   logic        clk;
   logic        reset_l;
   logic        in_valid;
   logic        in_ready;
   logic [10:0] in_data;
   logic        abort;
   logic        ser_out;
   logic        ser_valid;
   logic        ser_ready;
   logic        sof;
   logic        eof;
   logic [4:0]  crc5out;
   logic        crc_done;
   logic        busy;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [4:0]  last_crc;

   typedef struct {
      logic [10:0] pl;
      logic [4:0]  crc;
   } vec_t;

   vec_t vecs[3];

   crc5_frame_ctrl #(
      .PAYLOAD_W  (11),
      .CRC_INIT   (5'b11111),
      .INVERT_OUT (1'b1)
   ) dut (
      .clk       (clk),
      .reset_l   (reset_l),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .abort     (abort),
      .ser_out   (ser_out),
      .ser_valid (ser_valid),
      .ser_ready (ser_ready),
      .sof       (sof),
      .eof       (eof),
      .crc5out   (crc5out),
      .crc_done  (crc_done),
      .busy      (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [4:0] model_step(input logic [4:0] l, input logic b);
      logic [4:0] r;
      r = {l[3:0], 1'b0};
      if (l[4] != b) r = r ^ 5'b00101;
      return r;
   endfunction

   function automatic logic [4:0] ref_crc(input logic [10:0] p);
      logic [4:0] l;
      l = 5'b11111;
      for (int i = 0; i < 11; i++) l = model_step(l, p[i]);
      return ~l;
   endfunction

   // Called at a negedge with the DUT idle; returns at the negedge of cycle 1.
   task automatic start_frame(input logic [10:0] pl);
      int g = 0;
      in_valid = 1'b1;
      in_data  = pl;
      while (!in_ready && g < 20) begin
         @(negedge clk);
         g++;
      end
      check("accept_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic collect(input bit stall, output logic [15:0] bits, output int cyc);
      int   beats     = 0;
      logic p_out     = 1'b0;
      logic p_sof     = 1'b0;
      logic p_eof     = 1'b0;
      bit   was_stall = 1'b0;
      bit   rdy;
      bits = '0;
      cyc  = 1;
      while (beats < 16 && cyc < 400) begin
         check("ser_valid", 32'(ser_valid), 32'd1);
         check("sof", 32'(sof), 32'(beats == 0));
         check("eof", 32'(eof), 32'(beats == 15));
         if (was_stall) begin
            check("hold_out", 32'(ser_out), 32'(p_out));
            check("hold_sof", 32'(sof), 32'(p_sof));
            check("hold_eof", 32'(eof), 32'(p_eof));
         end
         rdy = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
         ser_ready = rdy;
         if (rdy) begin
            bits[beats] = ser_out;
            beats++;
         end
         p_out     = ser_out;
         p_sof     = sof;
         p_eof     = eof;
         was_stall = !rdy;
         @(negedge clk);
         cyc++;
      end
      check("frame_beats", 32'(beats), 32'd16);
      ser_ready = 1'b1;
   endtask

   task automatic check_frame(input string name, input logic [10:0] pl, input logic [4:0] exp,
                              input bit stall);
      logic [15:0] b;
      int          cyc;
      logic [4:0]  l;
      start_frame(pl);
      collect(stall, b, cyc);
      check({name, " data"}, 32'(b[10:0]), 32'(pl));
      check({name, " wire_crc"}, 32'({b[11], b[12], b[13], b[14], b[15]}), 32'(exp));
      check({name, " crc5out"}, 32'(crc5out), 32'(exp));
      check({name, " crc_done"}, 32'(crc_done), 32'd1);
      check({name, " busy"}, 32'(busy), 32'd0);
      if (!stall) check({name, " done_cycle"}, 32'(cyc), 32'd17);
      l = 5'b11111;
      for (int i = 0; i < 16; i++) l = model_step(l, b[i]);
      check({name, " residual"}, 32'(l), 32'(5'b01100));
      last_crc = exp;
      @(negedge clk);
      check({name, " done_pulse"}, 32'(crc_done), 32'd0);
   endtask

   task automatic back_to_back(input logic [10:0] p1, input logic [4:0] c1,
                               input logic [10:0] p2, input logic [4:0] c2);
      logic [39:0] sv_a, sof_a, eof_a, done_a, rdy_a;
      logic [4:0]  crc_a[40];
      int          hs = 0;
      int          n_sof = 0;
      int          n_eof = 0;
      bit          take;
      logic [4:0]  prev = last_crc;
      in_valid  = 1'b1;
      in_data   = p1;
      ser_ready = 1'b1;
      for (int t = 0; t < 40; t++) begin
         sv_a[t]   = ser_valid;
         sof_a[t]  = sof;
         eof_a[t]  = eof;
         done_a[t] = crc_done;
         rdy_a[t]  = in_ready;
         crc_a[t]  = crc5out;
         take      = in_valid && in_ready;
         @(posedge clk);
         @(negedge clk);
         if (take) begin
            hs++;
            if (hs == 1) in_data = p2;
            else in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      for (int t = 0; t < 40; t++) begin
         n_sof += int'(sof_a[t]);
         n_eof += int'(eof_a[t]);
      end
      check("b2b sof1", 32'(sof_a[1]), 32'd1);
      check("b2b crc_hold", 32'(crc_a[11]), 32'(prev));
      check("b2b crc_upd", 32'(crc_a[12]), 32'(c1));
      check("b2b eof1", 32'(eof_a[16]), 32'd1);
      check("b2b done1", 32'(done_a[17]), 32'd1);
      check("b2b gap_idle", 32'(sv_a[17]), 32'd0);
      check("b2b gap_ready", 32'(rdy_a[17]), 32'd1);
      check("b2b sof2", 32'(sof_a[18]), 32'd1);
      check("b2b crc1", 32'(crc_a[17]), 32'(c1));
      check("b2b eof2", 32'(eof_a[33]), 32'd1);
      check("b2b done2", 32'(done_a[34]), 32'd1);
      check("b2b crc2", 32'(crc_a[34]), 32'(c2));
      check("b2b n_sof", 32'(n_sof), 32'd2);
      check("b2b n_eof", 32'(n_eof), 32'd2);
      last_crc = c2;
   endtask

   initial begin
      reset_l   = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      abort     = 1'b0;
      ser_ready = 1'b1;
      last_crc  = 5'b00000;

      vecs[0] = '{pl: 11'h000, crc: 5'b01000};
      vecs[1] = '{pl: 11'h7FF, crc: 5'b00010};
      vecs[2] = '{pl: 11'h001, crc: 5'b10111};

      #3;
      check("rst in_ready", 32'(in_ready), 32'd0);
      check("rst ser_valid", 32'(ser_valid), 32'd0);
      check("rst ser_out", 32'(ser_out), 32'd0);
      check("rst sof_eof", 32'({sof, eof}), 32'd0);
      check("rst crc_done", 32'(crc_done), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst crc5out", 32'(crc5out), 32'd0);
      #9 reset_l = 1'b1;
      @(negedge clk);
      check("post_rst in_ready", 32'(in_ready), 32'd1);
      check("post_rst busy", 32'(busy), 32'd0);

      foreach (vecs[i]) check_frame($sformatf("vec%0d", i), vecs[i].pl, vecs[i].crc, 1'b0);

      check_frame("stall", 11'h000, 5'b01000, 1'b1);

      back_to_back(11'h001, 5'b10111, 11'h7FF, 5'b00010);

      // Abort on data bit 6
      start_frame(11'h3C3);
      repeat (6) @(negedge clk);
      check("abort6 sof", 32'(sof), 32'd0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      #1;
      check("abort6 busy", 32'(busy), 32'd0);
      check("abort6 ser_valid", 32'(ser_valid), 32'd0);
      check("abort6 in_ready", 32'(in_ready), 32'd1);
      check("abort6 crc5out", 32'(crc5out), 32'(last_crc));
      repeat (3) begin
         check("abort6 no_done", 32'(crc_done), 32'd0);
         @(negedge clk);
      end

      // Abort on the final data beat must not publish a new field
      start_frame(11'h7A5);
      repeat (10) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort10 crc5out", 32'(crc5out), 32'(last_crc));
      check("abort10 busy", 32'(busy), 32'd0);
      @(negedge clk);
      check("abort10 no_done", 32'(crc_done), 32'd0);

      // Abort in IDLE blocks the handshake
      abort    = 1'b1;
      in_valid = 1'b1;
      in_data  = 11'h155;
      #1;
      check("abort_idle in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      check("abort_idle busy", 32'(busy), 32'd0);
      in_valid = 1'b0;
      abort    = 1'b0;
      @(negedge clk);
      check("abort_idle still_idle", 32'(ser_valid), 32'd0);

      // Asynchronous reset in the CRC phase
      start_frame(11'h2A5);
      repeat (12) @(negedge clk);
      check("arst pre busy", 32'(busy), 32'd1);
      check("arst pre eof", 32'(eof), 32'd0);
      #2 reset_l = 1'b0;
      #1;
      check("arst busy", 32'(busy), 32'd0);
      check("arst ser_valid", 32'(ser_valid), 32'd0);
      check("arst ser_out", 32'(ser_out), 32'd0);
      check("arst in_ready", 32'(in_ready), 32'd0);
      check("arst sof_eof", 32'({sof, eof}), 32'd0);
      check("arst crc5out", 32'(crc5out), 32'd0);
      check("arst crc_done", 32'(crc_done), 32'd0);
      last_crc = 5'b00000;
      @(negedge clk);
      #2 reset_l = 1'b1;
      @(negedge clk);
      check("arst rel ser_valid", 32'(ser_valid), 32'd0);
      check("arst rel in_ready", 32'(in_ready), 32'd1);
      check_frame("post_arst", 11'h000, 5'b01000, 1'b0);

      for (int k = 0; k < 1000; k++) begin
         logic [10:0] p;
         p = 11'($urandom);
         check_frame("rand", p, ref_crc(p), (k % 8) == 7);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
